// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order imem requests
// and buffers responses in a fetch queue feeding IF/ID, with redirect flush and stale drop.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_vld
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  logic [31:0]   pc_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] q_count_q;
  logic [PW-1:0] if_wr_q;
  logic [PW-1:0] if_rd_q;
  logic [PW-1:0] fq_wr_q;
  logic [PW-1:0] fq_rd_q;

  logic [31:0]   if_pc_mem [QDEPTH];
  fq_entry_t     fq_mem    [QDEPTH];

  logic [OW-1:0] occupancy;
  logic          credit_ok;
  logic          grant;
  logic          resp;
  logic          resp_keep;
  logic          pop;
  fq_entry_t     head;
  fq_entry_t     new_entry;
  logic          unused_redirect_lsb;

  // Every granted request owns a queue slot until it is popped, so the queue cannot overflow.
  assign occupancy  = OW'(inflight_q) + OW'(q_count_q);
  assign credit_ok  = occupancy < OW'(QDEPTH);
  assign o_imem_req = credit_ok & ~i_redirect & ~i_reset;
  assign o_imem_addr = pc_q;
  assign grant      = o_imem_req & i_imem_gnt;

  // A response with nothing outstanding (e.g. issued before a reset) is spurious and ignored.
  assign resp      = i_imem_rvalid & (inflight_q != '0);
  assign resp_keep = resp & (drop_q == '0) & ~i_redirect;

  assign o_vld = (q_count_q != '0);
  assign pop   = o_vld & ~i_stall & ~i_redirect;

  assign head      = fq_mem[fq_rd_q];
  assign new_entry = '{pc: if_pc_mem[if_rd_q], instr: i_imem_rdata};

  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    o_pc    = 32'h0;
    o_instr = NOP_INSTR;
    if (o_vld) begin
      o_pc    = head.pc;
      o_instr = head.instr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      q_count_q  <= '0;
      if_wr_q    <= '0;
      if_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
    end else begin
      if (i_redirect) begin
        pc_q <= {i_redirect_pc[31:2], 2'b00};
      end else if (grant) begin
        pc_q <= pc_q + 32'd4;
      end

      if (grant && !resp) begin
        inflight_q <= inflight_q + CW'(1);
      end else if (resp && !grant) begin
        inflight_q <= inflight_q - CW'(1);
      end

      if (grant) begin
        if_wr_q <= if_wr_q + PW'(1);
      end
      if (resp) begin
        if_rd_q <= if_rd_q + PW'(1);
      end

      // Everything still outstanding after a redirect is wrong-path and gets discarded on return.
      if (i_redirect) begin
        drop_q <= inflight_q - CW'(resp);
      end else if (resp && (drop_q != '0)) begin
        drop_q <= drop_q - CW'(1);
      end

      if (i_redirect) begin
        q_count_q <= '0;
        fq_wr_q   <= '0;
        fq_rd_q   <= '0;
      end else begin
        if (resp_keep) begin
          fq_wr_q <= fq_wr_q + PW'(1);
        end
        if (pop) begin
          fq_rd_q <= fq_rd_q + PW'(1);
        end
        if (resp_keep && !pop) begin
          q_count_q <= q_count_q + CW'(1);
        end else if (pop && !resp_keep) begin
          q_count_q <= q_count_q - CW'(1);
        end
      end
    end
  end

  // NOTE: storage arrays are not reset; the reset pointers and counts make stale contents unreachable.
  always_ff @(posedge i_clk) begin
    if (grant) begin
      if_pc_mem[if_wr_q] <= pc_q;
    end
    if (resp_keep && !i_reset) begin
      fq_mem[fq_wr_q] <= new_entry;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order imem model with configurable latency,
// expected fetch stream tracked by the bench itself.
module tb_if_fetch_unit;

  localparam int QDEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_vld;

  always #5 i_clk = ~i_clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .o_vld         (o_vld)
  );

  typedef struct {
    logic [31:0] addr;
    int          cnt;
  } pend_t;

  int          total = 0;
  int          bad   = 0;
  pend_t       pend[$];
  int          lat = 1;
  bit          lat_rand = 1'b0;
  bit          chk_credit = 1'b0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_req = 32'h0;
  int          qest = 0;
  int          stale = 0;
  logic        s_vld, s_req;
  logic [31:0] s_pc, s_instr, s_addr;
  logic [31:0] t5_start;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_0F96;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory drives the oldest due response, outputs are sampled mid-cycle,
  // then the memory model and expected stream advance just after the edge.
  task automatic step();
    logic  granted;
    pend_t e;
    if (pend.size() > 0 && pend[0].cnt <= 1) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = instr_of(pend[0].addr);
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0;
    end
    @(negedge i_clk);
    s_vld   = o_vld;
    s_pc    = o_pc;
    s_instr = o_instr;
    s_req   = o_imem_req;
    s_addr  = o_imem_addr;
    if (!s_vld) begin
      check("empty_pc", s_pc, 32'h0);
      check("empty_instr", s_instr, 32'h0000_0013);
    end else if (!i_stall && !i_redirect && !i_reset) begin
      check("pop_pc", s_pc, exp_pc);
      check("pop_instr", s_instr, instr_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      qest--;
    end
    granted = s_req & i_imem_gnt;
    if (granted) check("req_addr", s_addr, exp_req);
    if (chk_credit) check("credit", 32'(pend.size() + qest <= QDEPTH), 32'd1);
    @(posedge i_clk);
    #1;
    foreach (pend[i]) if (pend[i].cnt > 1) pend[i].cnt--;
    if (i_imem_rvalid) begin
      void'(pend.pop_front());
      if (!i_redirect && !i_reset) begin
        if (stale > 0) stale--;
        else qest++;
      end
    end
    if (granted) begin
      exp_req = exp_req + 32'd4;
      e.addr = s_addr;
      e.cnt  = lat_rand ? int'($urandom_range(1, 3)) : lat;
      pend.push_back(e);
    end
    if (i_redirect || i_reset) begin
      qest  = 0;
      stale = pend.size();
    end
  endtask

  task automatic wait_vld(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      step();
      if (s_vld) break;
    end
    check(tag, 32'(s_vld), 32'd1);
  endtask

  initial begin
    i_reset = 1'b1;
    i_stall = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;
    i_imem_gnt = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata = 32'h0;

    repeat (3) begin
      step();
      check("rst_req", 32'(s_req), 32'd0);
      check("rst_vld", 32'(s_vld), 32'd0);
    end

    // 1: sequential fetch from reset with a 1-cycle memory
    i_reset = 1'b0;
    i_imem_gnt = 1'b1;
    lat = 1;
    step();
    check("t1_c0_req", 32'(s_req), 32'd1);
    check("t1_c0_addr", s_addr, 32'h0);
    check("t1_c0_vld", 32'(s_vld), 32'd0);
    step();
    check("t1_c1_addr", s_addr, 32'h4);
    check("t1_c1_vld", 32'(s_vld), 32'd0);
    step();
    check("t1_c2_vld", 32'(s_vld), 32'd1);
    check("t1_c2_pc", s_pc, 32'h0);
    step();
    check("t1_c3_pc", s_pc, 32'h4);
    step();
    check("t1_c4_pc", s_pc, 32'h8);

    // 2: stall for 6 cycles, queue fills, head frozen
    i_stall = 1'b1;
    repeat (6) begin
      step();
      check("t2_hold_pc", s_pc, 32'hC);
      check("t2_hold_instr", s_instr, instr_of(32'hC));
    end
    check("t2_full_req", 32'(s_req), 32'd0);
    i_stall = 1'b0;
    repeat (6) step();

    // 3: redirect with two responses in flight (2-cycle memory)
    lat = 2;
    repeat (4) step();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0103;
    exp_pc = 32'h100;
    exp_req = 32'h100;
    step();
    check("t3_redir_req", 32'(s_req), 32'd0);
    i_redirect = 1'b0;
    step();
    check("t3_req", 32'(s_req), 32'd1);
    check("t3_addr", s_addr, 32'h100);
    check("t3_vld_after", 32'(s_vld), 32'd0);
    wait_vld("t3_first_vld", 12);
    check("t3_first_pc", s_pc, 32'h100);

    // 3b: PC wraps from 32'hFFFF_FFFC to 0
    lat = 1;
    repeat (4) step();
    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF9;
    exp_pc = 32'hFFFF_FFF8;
    exp_req = 32'hFFFF_FFF8;
    step();
    i_redirect = 1'b0;
    wait_vld("t3b_first_vld", 12);
    check("t3b_pc0", s_pc, 32'hFFFF_FFF8);
    step();
    check("t3b_pc1", s_pc, 32'hFFFF_FFFC);
    step();
    check("t3b_pc2", s_pc, 32'h0);
    step();
    check("t3b_pc3", s_pc, 32'h4);

    // 4: redirect and stall together on a full queue
    i_stall = 1'b1;
    repeat (5) step();
    check("t4_full_req", 32'(s_req), 32'd0);
    check("t4_full_vld", 32'(s_vld), 32'd1);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h200;
    exp_pc = 32'h200;
    exp_req = 32'h200;
    step();
    i_redirect = 1'b0;
    step();
    check("t4_flush_vld", 32'(s_vld), 32'd0);
    i_stall = 1'b0;
    step();
    check("t4_r2_vld", 32'(s_vld), 32'd0);
    step();
    check("t4_r3_vld", 32'(s_vld), 32'd1);
    check("t4_r3_pc", s_pc, 32'h200);

    // 5: random grant, random 1-3 cycle latency, occasional stall
    t5_start = exp_pc;
    chk_credit = 1'b1;
    lat_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      i_imem_gnt = 1'($urandom_range(0, 1));
      i_stall = ($urandom_range(0, 3) == 0);
      step();
    end
    chk_credit = 1'b0;
    lat_rand = 1'b0;
    i_stall = 1'b0;
    check("t5_progress", 32'(exp_pc - t5_start >= 32'd80), 32'd1);

    // 6: reset with two requests in flight, late responses ignored
    i_imem_gnt = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (pend.size() == 0 && !s_vld) break;
    end
    check("t6_drained", 32'(s_vld), 32'd0);
    lat = 3;
    i_imem_gnt = 1'b1;
    step();
    check("t6_req0", 32'(s_req), 32'd1);
    step();
    check("t6_req1", 32'(s_req), 32'd1);
    i_reset = 1'b1;
    i_imem_gnt = 1'b0;
    exp_pc = 32'h0;
    exp_req = 32'h0;
    step();
    check("t6_rst_req", 32'(s_req), 32'd0);
    i_reset = 1'b0;
    repeat (4) begin
      step();
      check("t6_late_vld", 32'(s_vld), 32'd0);
    end
    check("t6_restart_req", 32'(s_req), 32'd1);
    check("t6_restart_addr", s_addr, 32'h0);
    lat = 1;
    i_imem_gnt = 1'b1;
    step();
    step();
    step();
    check("t6_vld", 32'(s_vld), 32'd1);
    check("t6_pc0", s_pc, 32'h0);
    step();
    check("t6_pc1", s_pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
